// File: rtl/reg_dump_pkg.sv
// Shared definitions for reg_dump_reader: FSM state encoding and default widths.
package reg_dump_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Streams registers first_idx..last_idx from a register-file read port as ready/valid words.
// Optional REG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_e            state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] last_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic [ADDR_W-1:0] out_idx_r;
  logic              out_last_r;
  logic              done_r;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  assign rf_addr   = idx_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign done      = done_r;
  assign busy      = (state_r != ST_IDLE);

  // Dump sequencer: fetch one register per READ, present it in SEND until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {ADDR_W{1'b0}};
      last_r      <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_idx_r   <= {ADDR_W{1'b0}};
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_r      <= {DATA_W{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      // Abort wins over everything, including a handshake in the same cycle.
      if (abort && (state_r != ST_IDLE)) begin
        state_r     <= ST_IDLE;
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              if (first_idx <= last_idx) begin
                idx_r   <= first_idx;
                last_r  <= last_idx;
                state_r <= ST_READ;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_r  <= {DATA_W{1'b0}};
`endif
              end else begin
                state_r <= ST_FINISH;
                done_r  <= 1'b1;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_READ: begin
            out_data_r  <= rf_data;
            out_idx_r   <= idx_r;
`ifdef REG_DUMP_CHECKSUM_EN
            out_last_r  <= 1'b0;
`else
            out_last_r  <= (idx_r == last_r);
`endif
            out_valid_r <= 1'b1;
            state_r     <= ST_SEND;
          end
          ST_SEND: begin
            if (out_ready) begin
              if (out_last_r) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
                state_r     <= ST_FINISH;
                done_r      <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
              end else if (idx_r == last_r) begin
                // Last register accepted: turn straight into the checksum word.
                out_data_r  <= csum_r ^ out_data_r;
                out_idx_r   <= {ADDR_W{1'b0}};
                out_last_r  <= 1'b1;
`endif
              end else begin
                out_valid_r <= 1'b0;
                idx_r       <= idx_r + ADDR_W'(1'b1);
                state_r     <= ST_READ;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_r      <= csum_r ^ out_data_r;
`endif
              end
            end else begin
              state_r <= ST_SEND;
            end
          end
          ST_FINISH: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter: DATA_W, 32, register word width.
REQ-002 Parameter: ADDR_W, 5, register index width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 start  input  1  one-cycle dump request; sampled only in IDLE.
REQ-006 abort  input  1  cancel the dump in progress.
REQ-007 first_idx  input  ADDR_W  first register index, sampled with start.
REQ-008 last_idx  input  ADDR_W  last register index, sampled with start.
REQ-009 rf_addr  output  ADDR_W  read address to the register-file read port.
REQ-010 rf_data  input  DATA_W  combinational read data returned for rf_addr.
REQ-011 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-012 out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-013 out_data  output  DATA_W  register contents.
REQ-014 out_idx  output  ADDR_W  index of the register in out_data.
REQ-015 out_last  output  1  final word of the dump.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 The FSM SHALL have states IDLE, READ, SEND, FINISH.
REQ-019 In IDLE with start=1 and first_idx<=last_idx, the block SHALL latch both indices, load idx=first_idx and go to READ.
REQ-020 In IDLE with start=1 and first_idx>last_idx, the block SHALL emit no words and go to FINISH.
REQ-021 rf_addr SHALL equal idx in every state; in READ, rf_data SHALL be registered into out_data, and idx into out_idx, and the FSM SHALL enter SEND.
REQ-022 In SEND, out_valid SHALL be 1 and out_data/out_idx/out_last SHALL stay stable until out_ready=1.
REQ-023 On a SEND handshake, the block SHALL go to FINISH if out_last=1; otherwise it SHALL increment idx and go to READ.
REQ-024 Each word SHALL take exactly 2 cycles with out_ready held high (READ, SEND).
REQ-025 In FINISH, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, drop out_valid, and suppress done; abort has priority over a simultaneous handshake.
REQ-028 A range ending at index 31 SHALL terminate on out_last and SHALL NOT wrap idx to 0.

Reset
REQ-029 With rst=0, the block SHALL immediately enter IDLE and clear idx, out_valid, out_data, out_idx, out_last, done and rf_addr to 0, independent of clk.
REQ-030 Reset asserted mid-dump SHALL discard the dump without a done pulse.

Configuration
REQ-031 With macro REG_DUMP_CHECKSUM_EN defined, after the last register the block SHALL send one extra word: the XOR of all words sent, with out_idx=0 and out_last=1 (the register word then has out_last=0).
REQ-032 Without REG_DUMP_CHECKSUM_EN, out_last SHALL be 1 on the last register word, and no checksum logic SHALL exist.
REQ-033 With the checksum enabled and an empty range (REQ-020), the block SHALL still send nothing.

Structure
REQ-034 The FSM state encoding and the DATA_W/ADDR_W defaults SHALL live in a shared package, reg_dump_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the checksum accumulator is inline.

Verification
REQ-036 Registers preloaded x1..x3 = 0x11, 0x22, 0x33; start with first=1, last=3, out_ready=1 -> words (1,0x11), (2,0x22), (3,0x33) on cycles 2, 4, 6; out_last on index 3; done one cycle later.
REQ-037 Same dump with out_ready=0 for 5 cycles on the index-2 word -> out_data holds 0x22 stable for the full stall; the word is accepted once.
REQ-038 start with first=5, last=4 -> no out_valid; done 1 cycle later.
REQ-039 abort asserted during SEND of index 2 -> out_valid=0 next cycle, no done, busy=0; a new start is accepted afterwards.
REQ-040 rst pulled low mid-dump -> all outputs 0 asynchronously, before the next clk edge.
REQ-041 With REG_DUMP_CHECKSUM_EN and the dump of REQ-036 -> a fourth word 0x00 (0x11^0x22^0x33) with out_idx=0 and out_last=1.
